// File: rtl/bidir_arb_pkg.sv
// Purpose: shared types and defaults for the bidirectional turnaround arbiter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package bidir_arb_pkg;

    localparam int TURN_CYC_DEF = 2;
    localparam int HOLD_MAX_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP_A = 3'd1,
        OWN_A   = 3'd2,
        SETUP_B = 3'd3,
        OWN_B   = 3'd4,
        REL     = 3'd5
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_A) ? SIDE_B : SIDE_A;
    endfunction

    function automatic state_t setup_of(input side_t s);
        return (s == SIDE_A) ? SETUP_A : SETUP_B;
    endfunction

endpackage

// File: rtl/bidir_turn_cnt.sv
// Purpose: turnaround countdown; load starts a window, done pulses in its last cycle.
// Latency: done is high in the cycle after (load_val) decrements following load.
// Backpressure: none; a new load always restarts the window, count never wraps below 0.
module bidir_turn_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] cnt_q;
    logic       active_q;

    // Count down from the loaded value and stop at zero; active marks a live window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= load_val;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == 4'd0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign done = active_q && (cnt_q == 4'd0);

endmodule

// File: rtl/bidir_turn_arbiter.sv
// Purpose: arbitrates ownership of a shared bidirectional net between sides A and B with turnaround gaps.
// Latency: grant rises TURN_CYC+1 edges after the request is sampled in IDLE; outputs lag state by one edge.
// Backpressure: owner is forced off after HOLD_MAX cycles only if the other side is requesting.
module bidir_turn_arbiter
    import bidir_arb_pkg::*;
#(
    parameter int TURN_CYC = TURN_CYC_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b,
    output logic oe_a,
    output logic oe_b,
    output logic link_en,
    output logic dir,
    output logic busy
);

    localparam logic [3:0] TURN_LOAD  = 4'(TURN_CYC - 1);
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    side_t      last_owner_q;
    logic [7:0] hold_q;
    logic       turn_load;
    logic       turn_done;
    logic       own_a_entry;
    logic       own_b_entry;

    bidir_turn_cnt u_turn_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (turn_load),
        .load_val (TURN_LOAD),
        .done     (turn_done)
    );

    // Next-state decode; the turnaround window reloads on every SETUP/REL entry.
    always_comb begin
        state_d   = state_q;
        turn_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = setup_of(other_side(last_owner_q));
                end else if (req_a) begin
                    state_d = SETUP_A;
                end else if (req_b) begin
                    state_d = SETUP_B;
                end
            end
            SETUP_A: begin
                if (!req_a) begin
                    state_d = IDLE;
                end else if (turn_done) begin
                    state_d = OWN_A;
                end
            end
            SETUP_B: begin
                if (!req_b) begin
                    state_d = IDLE;
                end else if (turn_done) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a || ((hold_q == HOLD_LIMIT) && req_b)) begin
                    state_d = REL;
                end
            end
            OWN_B: begin
                if (!req_b || ((hold_q == HOLD_LIMIT) && req_a)) begin
                    state_d = REL;
                end
            end
            REL: begin
                // last_owner is the side that just released; offer the net to the other side first.
                if (turn_done) begin
                    if (last_owner_q == SIDE_A) begin
                        if (req_b) begin
                            state_d = SETUP_B;
                        end else if (req_a) begin
                            state_d = SETUP_A;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (req_a) begin
                            state_d = SETUP_A;
                        end else if (req_b) begin
                            state_d = SETUP_B;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        turn_load = (state_d != state_q) &&
                    ((state_d == SETUP_A) || (state_d == SETUP_B) || (state_d == REL));
    end

    assign own_a_entry = (state_q == SETUP_A) && (state_d == OWN_A);
    assign own_b_entry = (state_q == SETUP_B) && (state_d == OWN_B);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin memory and saturating hold counter for the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= SIDE_B;
            hold_q       <= 8'd0;
        end else if (own_a_entry) begin
            last_owner_q <= SIDE_A;
            hold_q       <= 8'd0;
        end else if (own_b_entry) begin
            last_owner_q <= SIDE_B;
            hold_q       <= 8'd0;
        end else if ((state_q == OWN_A) || (state_q == OWN_B)) begin
            if (hold_q != HOLD_LIMIT) begin
                hold_q <= hold_q + 8'd1;
            end
        end
    end

    // Registered output decode of the state; reset clears drivers without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            oe_a    <= 1'b0;
            oe_b    <= 1'b0;
            link_en <= 1'b0;
            dir     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            grant_a <= (state_q == OWN_A);
            grant_b <= (state_q == OWN_B);
            oe_a    <= (state_q == OWN_A);
            oe_b    <= (state_q == OWN_B);
            link_en <= (state_q == OWN_A) || (state_q == OWN_B);
            busy    <= (state_q != IDLE);
            if (state_q == OWN_A) begin
                dir <= 1'b0;
            end else if (state_q == OWN_B) begin
                dir <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bidir_turn_arbiter.sv
// Purpose: self-checking bench for bidir_turn_arbiter with TURN_CYC=2, HOLD_MAX=4.
// Latency: expected output vectors are queued per driven cycle and compared one edge later.
// Backpressure: n/a.
module tb_bidir_turn_arbiter;

    logic clk;
    logic rst_n;
    logic req_a;
    logic req_b;
    logic grant_a;
    logic grant_b;
    logic oe_a;
    logic oe_b;
    logic link_en;
    logic dir;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    int   last_a_hi = -100;
    int   last_b_hi = -100;
    logic prev_oe_a = 1'b0;
    logic prev_oe_b = 1'b0;

    bidir_turn_arbiter #(
        .TURN_CYC (2),
        .HOLD_MAX (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .oe_a    (oe_a),
        .oe_b    (oe_b),
        .link_en (link_en),
        .dir     (dir),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] obs_vec();
        return {grant_a, grant_b, oe_a, oe_b, link_en, dir, busy};
    endfunction

    // Drive one cycle of requests, queue the expected post-edge outputs, then compare.
    task automatic step(input string tag, input int k, input logic ra, input logic rb,
                        input logic ga, input logic gb, input logic d, input logic bz);
        logic [6:0] e;
        string      t;
        req_a = ra;
        req_b = rb;
        exp_q.push_back({ga, gb, ga, gb, ga | gb, d, bz});
        tag_q.push_back($sformatf("%s_k%0d", tag, k));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, 32'(obs_vec()), 32'(e));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'(obs_vec()), 32'd0);
        rst_n = 1'b1;
    endtask

    // Drivers must never overlap, and a fall on one side needs at least two idle cycles before the other rises.
    always @(negedge clk) begin
        if (oe_a || oe_b) begin
            check_eq("oe_exclusive", 32'(oe_a & oe_b), 32'd0);
        end
        if (oe_a && !prev_oe_a) begin
            check_eq("oe_gap_b_to_a", 32'((cyc - last_b_hi - 1) >= 2), 32'd1);
        end
        if (oe_b && !prev_oe_b) begin
            check_eq("oe_gap_a_to_b", 32'((cyc - last_a_hi - 1) >= 2), 32'd1);
        end
        if (oe_a) last_a_hi = cyc;
        if (oe_b) last_b_hi = cyc;
        prev_oe_a = oe_a;
        prev_oe_b = oe_b;
    end

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        #2;
        check_eq("reset_async_init", 32'(obs_vec()), 32'd0);

        // A alone: busy from edge 1, grant at edge 3, release when req_a drops.
        do_reset();
        for (int k = 0; k < 11; k++)
            step("a_alone", k, k < 6, 1'b0, (k >= 3) && (k <= 6), 1'b0, 1'b0, (k >= 1) && (k <= 8));

        // Tie after reset: A first, forced release at hold limit, B follows with dir=1.
        do_reset();
        for (int k = 0; k < 19; k++)
            step("tie_rr", k, k < 14, k < 14, (k >= 3) && (k <= 7), (k >= 12) && (k <= 14),
                 k >= 12, (k >= 1) && (k <= 16));

        // One-cycle B pulse: SETUP_B aborts with no grant.
        do_reset();
        for (int k = 0; k < 6; k++)
            step("b_pulse", k, 1'b0, k == 0, 1'b0, 1'b0, 1'b0, k == 1);

        // A held alone: ownership persists, hold counter saturates.
        do_reset();
        for (int k = 0; k < 24; k++)
            step("a_hold", k, 1'b1, 1'b0, k >= 3, 1'b0, 1'b0, k >= 1);
        check_eq("hold_sat", 32'(dut.hold_q), 32'd4);

        // After A owned, a fresh tie from IDLE goes to B.
        do_reset();
        for (int k = 0; k < 15; k++)
            step("rr_to_b", k, (k < 4) || (k >= 8), k >= 8, (k >= 3) && (k <= 4), k >= 11,
                 k >= 11, ((k >= 1) && (k <= 6)) || (k >= 9));

        // Forced release with the other side dropping: REL re-grants the same side.
        do_reset();
        for (int k = 0; k < 15; k++)
            step("same_side", k, 1'b1, k < 8, ((k >= 3) && (k <= 7)) || (k >= 12), 1'b0,
                 1'b0, k >= 1);

        // B owns, then asynchronous reset mid-ownership.
        do_reset();
        for (int k = 0; k < 6; k++)
            step("b_own", k, 1'b0, 1'b1, 1'b0, k >= 3, k >= 3, k >= 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_oe_b", 32'(oe_b), 32'd0);
        check_eq("arst_link_en", 32'(link_en), 32'd0);
        check_eq("arst_all", 32'(obs_vec()), 32'd0);

        // Reset restores A priority on a tie.
        do_reset();
        for (int k = 0; k < 6; k++)
            step("post_arst_tie", k, 1'b1, 1'b1, k >= 3, 1'b0, 1'b0, k >= 1);

        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
